// File: rtl/frame_deframer.sv
// Receive-side deframer: delimiter hunt, ESC unstuffing, type and CRC-32 check.
// Delivers the payload over a valid/ready handshake and strobes a confirmation code.
module frame_deframer #(
   parameter int unsigned DATA_SIZE   = 64,
   parameter int unsigned CRC_SIZE    = 4,
   parameter logic [7:0]  FRAME_START = 8'h06,
   parameter logic [7:0]  FRAME_END   = 8'h07,
   parameter logic [7:0]  ESC_VAL     = 8'h14,
   parameter logic [7:0]  ESC_XOR     = 8'h20,
   parameter logic [7:0]  FIRST_FRAME = 8'h10,
   parameter logic [7:0]  LAST_FRAME  = 8'h01,
   parameter logic [7:0]  NORMALNA    = 8'h02,
   parameter logic [7:0]  POJEDYNCZA  = 8'h03,
   parameter logic [7:0]  OKAY        = 8'h05,
   parameter logic [7:0]  ERROR       = 8'h04,
   parameter logic [7:0]  FATAL_ERROR = 8'h08
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [7:0]                       rx_data,
   input  logic                             rx_valid,
   output logic                             rx_ready,
   output logic [DATA_SIZE*8-1:0]           fout,
   output logic [$clog2(DATA_SIZE+1)-1:0]   fout_len,
   output logic [7:0]                       fout_type,
   output logic                             fout_valid,
   input  logic                             fout_ready,
   output logic [7:0]                       conf_code,
   output logic                             conf_valid,
   output logic [15:0]                      err_count
);

   localparam int unsigned BufBytes = DATA_SIZE + CRC_SIZE;
   localparam int unsigned CntW     = $clog2(BufBytes + 1);
   localparam int unsigned LenW     = $clog2(DATA_SIZE + 1);
   localparam logic [CntW-1:0] CrcCnt     = CntW'(CRC_SIZE);
   localparam logic [CntW-1:0] CntFull    = CntW'(BufBytes);
   localparam logic [31:0]     CrcPoly    = 32'hEDB88320;
   localparam logic [31:0]     CrcResidue = 32'hDEBB20E3;

   typedef enum logic [2:0] {
      StIdle, StType, StBody, StEsc, StCheck, StHold, StDiscard
   } state_e;

   state_e                  state_q, state_d;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [31:0]             crc_q, crc_d;
   logic [BufBytes*8-1:0]   buf_q, buf_d;
   logic [7:0]              type_q, type_d;
   logic [DATA_SIZE*8-1:0]  fout_q, fout_d;
   logic [LenW-1:0]         fout_len_q, fout_len_d;
   logic [7:0]              fout_type_q, fout_type_d;
   logic                    fout_valid_q, fout_valid_d;
   logic [7:0]              conf_code_q, conf_code_d;
   logic                    conf_valid_q, conf_valid_d;
   logic [15:0]             err_count_q, err_count_d;

   logic                    rx_acc;
   logic                    do_start, do_store, do_err, do_fatal, do_ok;
   logic [7:0]              store_byte;
   logic [CntW-1:0]         pay_len;

   function automatic logic [31:0] crc_next(input logic [31:0] crc, input logic [7:0] b);
      logic [31:0] c;
      c = crc ^ {24'h0, b};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CrcPoly) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic is_type(input logic [7:0] b);
      return (b == FIRST_FRAME) || (b == LAST_FRAME) || (b == NORMALNA) || (b == POJEDYNCZA);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         crc_q        <= 32'hFFFFFFFF;
         buf_q        <= '0;
         type_q       <= '0;
         fout_q       <= '0;
         fout_len_q   <= '0;
         fout_type_q  <= '0;
         fout_valid_q <= 1'b0;
         conf_code_q  <= '0;
         conf_valid_q <= 1'b0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         crc_q        <= crc_d;
         buf_q        <= buf_d;
         type_q       <= type_d;
         fout_q       <= fout_d;
         fout_len_q   <= fout_len_d;
         fout_type_q  <= fout_type_d;
         fout_valid_q <= fout_valid_d;
         conf_code_q  <= conf_code_d;
         conf_valid_q <= conf_valid_d;
         err_count_q  <= err_count_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      crc_d        = crc_q;
      buf_d        = buf_q;
      type_d       = type_q;
      fout_d       = fout_q;
      fout_len_d   = fout_len_q;
      fout_type_d  = fout_type_q;
      fout_valid_d = fout_valid_q;
      conf_code_d  = conf_code_q;
      conf_valid_d = 1'b0;
      err_count_d  = err_count_q;
      do_start     = 1'b0;
      do_store     = 1'b0;
      do_err       = 1'b0;
      do_fatal     = 1'b0;
      do_ok        = 1'b0;
      store_byte   = rx_data;
      pay_len      = cnt_q - CrcCnt;

      unique case (state_q)
         StIdle: begin
            if (rx_acc && (rx_data == FRAME_START)) do_start = 1'b1;
         end
         StType: begin
            if (rx_acc) begin
               if (rx_data == FRAME_START) begin
                  do_start = 1'b1;
               end else if (is_type(rx_data)) begin
                  type_d  = rx_data;
                  state_d = StBody;
               end else begin
                  do_err  = 1'b1;
                  state_d = StIdle;
               end
            end
         end
         StBody: begin
            if (rx_acc) begin
               if (rx_data == ESC_VAL) begin
                  state_d = StEsc;
               end else if (rx_data == FRAME_END) begin
                  state_d = StCheck;
               end else if (rx_data == FRAME_START) begin
                  do_err   = 1'b1;
                  do_start = 1'b1;
               end else begin
                  do_store = 1'b1;
               end
            end
         end
         StEsc: begin
            if (rx_acc) begin
               if (rx_data == FRAME_START) begin
                  do_err   = 1'b1;
                  do_start = 1'b1;
               end else if ((rx_data == FRAME_END) || (rx_data == ESC_VAL)) begin
                  do_err  = 1'b1;
                  state_d = StDiscard;
               end else begin
                  do_store   = 1'b1;
                  store_byte = rx_data ^ ESC_XOR;
                  state_d    = StBody;
               end
            end
         end
         StCheck: begin
            if ((cnt_q <= CrcCnt) || ((CRC_SIZE == 4) && (crc_q != CrcResidue))) begin
               do_err  = 1'b1;
               state_d = StIdle;
            end else begin
               do_ok   = 1'b1;
               state_d = StHold;
            end
         end
         StHold: begin
            if (fout_ready) begin
               fout_valid_d = 1'b0;
               state_d      = StIdle;
            end
         end
         StDiscard: begin
            if (rx_acc && (rx_data == FRAME_START)) do_start = 1'b1;
         end
         default: state_d = StIdle;
      endcase

      // A store into a full buffer overrides the return-to-BODY taken from ESC.
      if (do_store) begin
         if (cnt_q == CntFull) begin
            do_fatal = 1'b1;
            state_d  = StDiscard;
         end else begin
            for (int i = 0; i < BufBytes; i++) begin
               if (cnt_q == CntW'(i)) buf_d[BufBytes*8-1-8*i -: 8] = store_byte;
            end
            cnt_d = cnt_q + 1'b1;
            crc_d = crc_next(crc_q, store_byte);
         end
      end

      if (do_start) begin
         state_d = StType;
         cnt_d   = '0;
         crc_d   = 32'hFFFFFFFF;
         buf_d   = '0;
      end

      // CRC bytes that fall inside the visible window are masked to zero.
      if (do_ok) begin
         for (int i = 0; i < DATA_SIZE; i++) begin
            fout_d[DATA_SIZE*8-1-8*i -: 8] =
               (CntW'(i) < pay_len) ? buf_q[BufBytes*8-1-8*i -: 8] : 8'h00;
         end
         fout_len_d   = LenW'(pay_len);
         fout_type_d  = type_q;
         fout_valid_d = 1'b1;
         conf_code_d  = OKAY;
         conf_valid_d = 1'b1;
      end

      if (do_err || do_fatal) begin
         conf_code_d  = do_fatal ? FATAL_ERROR : ERROR;
         conf_valid_d = 1'b1;
         if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
      end
   end

   always_comb begin
      rx_ready   = !((state_q == StCheck) || (state_q == StHold));
      rx_acc     = rx_valid && rx_ready;
      fout       = fout_q;
      fout_len   = fout_len_q;
      fout_type  = fout_type_q;
      fout_valid = fout_valid_q;
      conf_code  = conf_code_q;
      conf_valid = conf_valid_q;
      err_count  = err_count_q;
   end

endmodule
